binary_ram_arbiter: RTL and testbench
=====================================

# binary_ram_arbiter

Two-requester round-robin controller for an array of `binary_cell` words: `DEPTH` rows of `WIDTH` cells, where each row shares one chip-select. Each access is sequenced as SETUP → ACCESS → HOLD, so chip-select is never high while `rd_wr` or write data change; this keeps the SR latches from being set or reset by glitches. The block sits between two bus masters and the cell array, and is the only driver of the array's `cs`, `rd_wr` and `wr_data` lines.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; cells per row.
- `DEPTH`, 16: number of rows.
- `AW`, 4: address width; must satisfy 2^AW ≥ DEPTH.

Ports (clock and reset are one clock, reset asynchronous active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0`, `req1`  in  1  access request. Held high, with `we`/`addr`/`wdata` stable, until the matching `ack` is seen.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  AW  word address.
- `wdata0`, `wdata1`  in  WIDTH  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  WIDTH  read result. Valid from `ack` onward; held until that port's next read completes.
- `err0`, `err1`  out  1  pulses with `ack` when `addr` ≥ DEPTH.
- `busy`  out  1  high in every non-IDLE state.
- `mem_cs`  out  DEPTH  one-hot row select; at most one bit high.
- `mem_rd_wr`  out  1  to all cells: 1 = read, 0 = write.
- `mem_wr_data`  out  WIDTH  to column `wr_data`.
- `mem_rd_data`  in  WIDTH  OR of all rows' `rd_data`; rows that are not selected output 0.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD. Registered state; Moore outputs.
- **IDLE**
  - Outputs: `mem_cs`=0, `mem_rd_wr`=1; `mem_wr_data` holds its last value.
  - If any `req` is high at the clock edge: the arbiter picks a winner and latches its `we`, `addr`, `wdata` and port index. Next state is SETUP.
- **Arbitration**
  - If only one `req` is high, that port wins.
  - If both are high, the port not served last wins.
  - The last-served pointer updates when a grant is made. It resets so that port 0 wins the first tie.
- **SETUP**
  - `mem_cs`=0.
  - `mem_rd_wr` = ~latched_we.
  - `mem_wr_data` = latched wdata for writes; unchanged for reads.
- **ACCESS**
  - `mem_cs[latched_addr]`=1. No bit is set if the address is out of range.
  - `mem_rd_wr` and `mem_wr_data` are the same as in SETUP.
  - For an in-range read, `mem_rd_data` is captured into the winner's `rdata` at the edge that ends ACCESS.
  - For an out-of-range read, 0 is captured instead.
- **HOLD**
  - `mem_cs`=0; `mem_rd_wr` and `mem_wr_data` are still unchanged.
  - The winner's `ack` is 1, and its `err` is 1 if the address was out of range.
  - Next state is always IDLE.
- The latched request is not re-sampled after IDLE. Changes on `req`/`addr`/`wdata` during SETUP–HOLD are ignored.
- A requester that still holds `req` in the IDLE cycle after its `ack` is treated as a new request.
- Out-of-range write: no row is touched, the array is unchanged, and the request is still acked.
- The other port's `ack`, `err` and `rdata` are unaffected by an access.

## Timing
- A `req` sampled high in IDLE cycle N gives SETUP in N+1, ACCESS in N+2, and `ack`/`rdata` valid in N+3. Latency is 3 cycles.
- Throughput is one access per 4 cycles. Under continuous requests from both ports, the ports alternate strictly.
- Worst-case wait for a port with both ports active: 7 cycles from `req` to `ack`.
- `rd_wr` and `wr_data` are stable one full cycle before and one full cycle after `mem_cs` is high. `mem_cs` is high for exactly 1 cycle per access.
- Reset values:
  - state = IDLE, `busy`=0.
  - `ack*`=0, `err*`=0.
  - `rdata*`=0.
  - `mem_cs`=0, `mem_rd_wr`=1, `mem_wr_data`=0.
  - last-served pointer = port 1, so port 0 wins the first tie.
- Reset asserted in any state, including mid-ACCESS:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - The in-flight access is dropped with no `ack`.
  - Cell contents are undefined only if the reset hit during a write ACCESS.
- A `req` held through reset release is served normally, starting from the first IDLE edge.

## Test plan
- **Basic write/read, port 0:** write 0xA5 to addr 3, then read addr 3 → `ack0` 3 cycles after each `req0`; `mem_cs`=0x0008 for exactly one cycle; `rdata0`=0xA5; `err0`=0.
- **Overwrite:** write 0xFF then 0x00 to addr 7 from port 1, then read → `rdata1`=0x00. This exercises the reset-side (R) input of every cell in the row.
- **Simultaneous requests:**
  - `req0` and `req1` both rise in the same cycle after reset; port 0 writes 0x11 to addr 2, port 1 reads addr 2.
  - Required: `ack0` at cycle 3, `ack1` at cycle 7, and `rdata1`=0x11.
  - Holding both requests high continuously must give strictly alternating acks.
- **Out-of-range address:** `addr0`=DEPTH → `mem_cs` stays 0 for the whole access; `ack0` and `err0` pulse together; `rdata0`=0; all rows are unchanged.
- **Reset mid-access:** assert `rst_n`=0 during the ACCESS of a read → `mem_cs`=0, `busy`=0, `rdata0`=0 immediately; no `ack0` ever appears for that request.
- **Strobe hygiene:** across random traffic, assert that `mem_rd_wr` and `mem_wr_data` never change in a cycle adjacent to any high `mem_cs` bit, and that `mem_cs` is always one-hot or zero.

Source files
------------

// File: rtl/binary_ram_arbiter.sv
// Two-port round-robin sequencer for an array of binary_cell words.
// Each access runs SETUP -> ACCESS -> HOLD so chip-select never overlaps a strobe or data edge.
module binary_ram_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             err0,
    output logic             err1,
    output logic             busy,
    output logic [DEPTH-1:0] mem_cs,
    output logic             mem_rd_wr,
    output logic [WIDTH-1:0] mem_wr_data,
    input  logic [WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               port_q, port_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               in_range_c;

    logic               ack0_q, ack0_d, ack1_q, ack1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic [WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic               busy_q, busy_d;
    logic [DEPTH-1:0]   cs_q, cs_d;
    logic               rd_wr_q, rd_wr_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;

    // Sequencing, arbitration and request latching; outputs are computed from the next state.
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    port_d  = (req0 && req1) ? ~last_q : req1;
                    last_d  = port_d;
                    we_d    = port_d ? we1 : we0;
                    addr_d  = port_d ? addr1 : addr0;
                    wdata_d = port_d ? wdata1 : wdata0;
                    state_d = SETUP;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_range_c = 32'(addr_d) < DEPTH;

        busy_d    = (state_d != IDLE);
        cs_d      = (state_d == ACCESS && in_range_c) ? (DEPTH'(1) << addr_d) : '0;
        rd_wr_d   = (state_d == IDLE) ? 1'b1 : ~we_d;
        wr_data_d = (state_d == SETUP && we_d) ? wdata_d : wr_data_q;

        ack0_d    = (state_d == HOLD) && !port_d;
        ack1_d    = (state_d == HOLD) &&  port_d;
        err0_d    = ack0_d && !in_range_c;
        err1_d    = ack1_d && !in_range_c;

        // Read data is taken on the edge that leaves ACCESS; out-of-range reads return zero.
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (state_q == ACCESS && !we_q) begin
            if (port_q) rdata1_d = in_range_c ? mem_rd_data : '0;
            else        rdata0_d = in_range_c ? mem_rd_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            busy_q    <= 1'b0;
            cs_q      <= '0;
            rd_wr_q   <= 1'b1;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            busy_q    <= busy_d;
            cs_q      <= cs_d;
            rd_wr_q   <= rd_wr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign err0        = err0_q;
    assign err1        = err1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign busy        = busy_q;
    assign mem_cs      = cs_q;
    assign mem_rd_wr   = rd_wr_q;
    assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_binary_ram_arbiter.sv
// Bench for binary_ram_arbiter: a behavioural cell array, a transaction-level memory model
// with round-robin ordering, and a strobe-hygiene monitor.
module tb_binary_ram_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0, req1, we0, we1;
    logic [AW-1:0]    addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             ack0, ack1, err0, err1, busy;
    logic [WIDTH-1:0] rdata0, rdata1;
    logic [DEPTH-1:0] mem_cs;
    logic             mem_rd_wr;
    logic [WIDTH-1:0] mem_wr_data;
    logic [WIDTH-1:0] mem_rd_data;

    binary_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .busy(busy),
        .mem_cs(mem_cs), .mem_rd_wr(mem_rd_wr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Cell array: a selected row latches wr_data while written, and drives its contents while read.
    logic [WIDTH-1:0] cells [DEPTH] = '{default: '0};
    always @(negedge clk) begin
        for (int r = 0; r < int'(DEPTH); r++)
            if (mem_cs[r] && !mem_rd_wr) cells[r] <= mem_wr_data;
    end
    always_comb begin
        mem_rd_data = '0;
        for (int r = 0; r < int'(DEPTH); r++)
            if (mem_cs[r] && mem_rd_wr) mem_rd_data = mem_rd_data | cells[r];
    end

    // Reference model: memory contents, expected held read data, last-served port.
    logic [WIDTH-1:0] model_mem [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] exp_rd [2];
    logic             model_last;

    function automatic void model_apply(input int p, input logic we, input logic [AW-1:0] a,
                                        input logic [WIDTH-1:0] d);
        bit inr;
        inr = 32'(a) < DEPTH;
        if (we && inr) model_mem[a] = d;
        if (!we) exp_rd[p] = inr ? model_mem[a] : '0;
        model_last = 1'(p);
    endfunction

    // Strobe monitor: no rd_wr/wr_data change across an edge touching a cs-high cycle.
    logic [DEPTH-1:0] cs_prev = '0;
    logic [DEPTH-1:0] cs_seen = '0;
    logic [WIDTH:0]   strobe_prev = '0;
    logic             mon_ok = 1'b0;
    int               cs_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && mon_ok) begin
            check("cs_onehot0", 32'($onehot0(mem_cs)), 32'd1);
            if (mem_cs != '0 || cs_prev != '0)
                check("strobe_stable", 32'({mem_rd_wr, mem_wr_data}), 32'(strobe_prev));
            if (mem_cs != '0)
                check("cs_single_cycle", 32'(cs_prev), 32'd0);
        end
        if (rst_n && mem_cs != '0) begin
            cs_cnt++;
            cs_seen = mem_cs;
        end
        cs_prev     = mem_cs;
        strobe_prev = {mem_rd_wr, mem_wr_data};
        mon_ok      = rst_n;
    end

    task automatic port_access(input int p, input logic we, input logic [AW-1:0] a,
                               input logic [WIDTH-1:0] d, output int lat,
                               output logic [WIDTH-1:0] rd, output logic er);
        lat = 0;
        if (p == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
        else        begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
        do begin
            @(negedge clk);
            lat++;
        end while (!((p == 0) ? ack0 : ack1) && lat < 40);
        rd = (p == 0) ? rdata0 : rdata1;
        er = (p == 0) ? err0 : err1;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic idle_checks(input int cs_before, input int cs_exp);
        @(negedge clk);
        check("ack_pulse", 32'({ack0, ack1}), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("cs_count", 32'(cs_cnt - cs_before), 32'(cs_exp));
    endtask

    task automatic run_one(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [WIDTH-1:0] d);
        int lat, cs0;
        logic [WIDTH-1:0] rd;
        logic er;
        bit inr;
        inr = 32'(a) < DEPTH;
        cs0 = cs_cnt;
        port_access(p, we, a, d, lat, rd, er);
        model_apply(p, we, a, d);
        check("latency", 32'(lat), 32'd3);
        check("err", 32'(er), 32'(!inr));
        check("rdata_own", 32'(rd), 32'(exp_rd[p]));
        check("rdata_other", 32'((p == 0) ? rdata1 : rdata0), 32'(exp_rd[1-p]));
        idle_checks(cs0, inr ? 1 : 0);
        if (inr) check("cs_row", 32'(cs_seen), 32'(DEPTH'(1) << a));
    endtask

    task automatic run_both(input logic w0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                            input logic w1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
        int l0, l1, cs0, win;
        logic [WIDTH-1:0] rd0, rd1;
        logic e0, e1;
        bit inr0, inr1;
        inr0 = 32'(a0) < DEPTH;
        inr1 = 32'(a1) < DEPTH;
        win  = model_last ? 0 : 1;
        cs0  = cs_cnt;
        fork
            port_access(0, w0, a0, d0, l0, rd0, e0);
            port_access(1, w1, a1, d1, l1, rd1, e1);
        join
        if (win == 0) begin model_apply(0, w0, a0, d0); model_apply(1, w1, a1, d1); end
        else          begin model_apply(1, w1, a1, d1); model_apply(0, w0, a0, d0); end
        check("both_lat0", 32'(l0), (win == 0) ? 32'd3 : 32'd7);
        check("both_lat1", 32'(l1), (win == 1) ? 32'd3 : 32'd7);
        check("both_err0", 32'(e0), 32'(!inr0));
        check("both_err1", 32'(e1), 32'(!inr1));
        check("both_rdata0", 32'(rd0), 32'(exp_rd[0]));
        check("both_rdata1", 32'(rd1), 32'(exp_rd[1]));
        idle_checks(cs0, int'(inr0) + int'(inr1));
    endtask

    // Both ports held high: acks must alternate, 3 cycles to the first and 4 between.
    task automatic run_alternate(input int n_acks);
        int exp_p, gap, seen;
        we0 = 1'b0; we1 = 1'b0; addr0 = AW'(1); addr1 = AW'(5);
        req0 = 1'b1; req1 = 1'b1;
        exp_p = model_last ? 0 : 1;
        gap = 0;
        seen = 0;
        while (seen < n_acks && gap < 20) begin
            @(negedge clk);
            gap++;
            if (ack0 || ack1) begin
                check("alt_port", 32'({ack1, ack0}), (exp_p == 1) ? 32'd2 : 32'd1);
                check("alt_gap", 32'(gap), (seen == 0) ? 32'd3 : 32'd4);
                exp_rd[exp_p] = model_mem[(exp_p == 1) ? 5 : 1];
                check("alt_rdata", 32'((exp_p == 1) ? rdata1 : rdata0), 32'(exp_rd[exp_p]));
                model_last = 1'(exp_p);
                exp_p = 1 - exp_p;
                seen++;
                gap = 0;
                if (seen == n_acks) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        check("alt_count", 32'(seen), 32'(n_acks));
        @(negedge clk);
    endtask

    initial begin
        int noack;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        model_last = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'({ack0, ack1, err0, err1}), 32'd0);
        check("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        check("rst_cs", 32'(mem_cs), 32'd0);
        check("rst_rd_wr", 32'(mem_rd_wr), 32'd1);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First tie after reset goes to port 0.
        run_both(1'b1, AW'(2), WIDTH'(8'h11), 1'b0, AW'(2), WIDTH'(0));
        run_one(0, 1'b1, AW'(3), WIDTH'(8'hA5));
        run_one(0, 1'b0, AW'(3), WIDTH'(0));
        run_one(1, 1'b1, AW'(7), WIDTH'(8'hFF));
        run_one(1, 1'b1, AW'(7), WIDTH'(8'h00));
        run_one(1, 1'b0, AW'(7), WIDTH'(0));
        run_one(0, 1'b1, AW'(DEPTH), WIDTH'(8'h5A));
        run_one(0, 1'b0, AW'(DEPTH), WIDTH'(0));
        for (int r = 0; r < int'(DEPTH); r++)
            check("row_contents", 32'(cells[r]), 32'(model_mem[r]));

        run_alternate(6);

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            if (kind == 2)
                run_both(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH + 1)), WIDTH'($urandom),
                         1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH + 1)), WIDTH'($urandom));
            else
                run_one(kind, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH + 1)),
                        WIDTH'($urandom));
        end
        for (int r = 0; r < int'(DEPTH); r++)
            check("row_contents_final", 32'(cells[r]), 32'(model_mem[r]));

        // Reset in the middle of a read ACCESS drops the access without an ack.
        run_one(0, 1'b1, AW'(4), WIDTH'(8'h3C));
        run_one(0, 1'b0, AW'(4), WIDTH'(0));
        we0 = 1'b0; addr0 = AW'(4); req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_cs", 32'(mem_cs), 32'(DEPTH'(1) << 4));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_cs", 32'(mem_cs), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rdata0", 32'(rdata0), 32'd0);
        check("mid_rst_ack0", 32'(ack0), 32'd0);
        check("mid_rst_rd_wr", 32'(mem_rd_wr), 32'd1);
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        model_last = 1'b1;
        noack = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack0) noack++;
        end
        check("mid_rst_no_ack", 32'(noack), 32'd0);

        // Pointer is back at its reset value: port 0 wins the tie again.
        run_both(1'b0, AW'(4), WIDTH'(0), 1'b0, AW'(3), WIDTH'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
